// File: rtl/calc_pkg.sv
// Shared types and the arithmetic for the calculator port responder.
// When CALC_SHIFT_EN is defined, cmds 5 and 6 execute as shifts. Otherwise they return INVALID.
package calc_pkg;

  localparam int CALC_DATA_W = 32;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    OVF     = 2'd2,
    INVALID = 2'd3
  } resp_e;

  typedef struct packed {
    logic [3:0]             cmd;
    logic [CALC_DATA_W-1:0] op1;
    logic [CALC_DATA_W-1:0] op2;
  } calc_req_t;

  typedef struct packed {
    resp_e                  resp;
    logic [CALC_DATA_W-1:0] data;
  } calc_rsp_t;

  typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_e;
  typedef enum logic {EX_IDLE, EX_BUSY} ex_state_e;

  function automatic calc_rsp_t calc_exec(input calc_req_t req);
    calc_rsp_t            rsp;
    logic [CALC_DATA_W:0] sum;
    rsp.resp = INVALID;
    rsp.data = '0;
    sum      = {1'b0, req.op1} + {1'b0, req.op2};
    case (cmd_e'(req.cmd))
      ADD: begin
        if (sum[CALC_DATA_W]) rsp.resp = OVF;
        else begin
          rsp.resp = OK;
          rsp.data = sum[CALC_DATA_W-1:0];
        end
      end
      SUB: begin
        if (req.op1 < req.op2) rsp.resp = OVF;
        else begin
          rsp.resp = OK;
          rsp.data = req.op1 - req.op2;
        end
      end
`ifdef CALC_SHIFT_EN
      SHL: begin
        rsp.resp = OK;
        rsp.data = req.op1 << req.op2[4:0];
      end
      SHR: begin
        rsp.resp = OK;
        rsp.data = req.op1 >> req.op2[4:0];
      end
`endif
      default: ;
    endcase
    return rsp;
  endfunction

endpackage

// File: rtl/calc_req_fifo.sv
// Request FIFO for the calculator responder. Its pointers are one bit wider than the index, so full and empty can be told apart.
// A push while full is accepted only if a pop happens on the same edge.
module calc_req_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  calc_req_t wr_data,
  output calc_req_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  calc_req_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/calc_port_responder.sv
// Single-channel calculator responder: two-cycle request capture, queued execution, one-cycle response pulse.
// Define CALC_SHIFT_EN to build the shift commands (5/6); without it they answer INVALID.
module calc_port_responder
  import calc_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   c_clk,
  input  logic                   reset,
  input  logic [3:0]             req_cmd_in,
  input  logic [CALC_DATA_W-1:0] req_data_in,
  output logic [1:0]             out_resp,
  output logic [CALC_DATA_W-1:0] out_data,
  output logic                   drop_err
);

  localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

  cap_state_e             cap_state_q, cap_state_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [CALC_DATA_W-1:0] op1_q, op1_d;
  ex_state_e              ex_state_q, ex_state_d;
  logic [3:0]             cnt_q, cnt_d;
  calc_req_t              cur_req_q, cur_req_d;
  calc_rsp_t              rsp_q, rsp_d;
  logic                   drop_err_q, drop_err_d;

  logic      push, pop, full, empty;
  calc_req_t push_req, head_req;

  assign push_req = '{cmd: cmd_q, op1: op1_q, op2: req_data_in};

  calc_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (c_clk),
    .rst_n   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (push_req),
    .rd_data (head_req),
    .full    (full),
    .empty   (empty)
  );

  // Capture: the command cycle latches cmd/op1, and the next cycle supplies op2 and pushes.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    cap_state_d = cap_state_q;
    cmd_d       = cmd_q;
    op1_d       = op1_q;
    push        = 1'b0;
    if (cap_state_q == CAP_IDLE) begin
      if (req_cmd_in != '0) begin
        cmd_d       = req_cmd_in;
        op1_d       = req_data_in;
        cap_state_d = CAP_OP2;
      end
    end else begin
      push        = 1'b1;
      cap_state_d = CAP_IDLE;
    end
  end

  // Execute: the result registers on the edge the counter reaches zero. The next entry is popped on that same edge.
  always_comb begin
    ex_state_d = ex_state_q;
    cnt_d      = cnt_q;
    cur_req_d  = cur_req_q;
    pop        = 1'b0;
    rsp_d      = '{resp: NONE, data: '0};
    if (ex_state_q == EX_IDLE) begin
      if (!empty) begin
        pop        = 1'b1;
        cur_req_d  = head_req;
        cnt_d      = CNT_RELOAD;
        ex_state_d = EX_BUSY;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      rsp_d = calc_exec(cur_req_q);
      if (!empty) begin
        pop       = 1'b1;
        cur_req_d = head_req;
        cnt_d     = CNT_RELOAD;
      end else begin
        ex_state_d = EX_IDLE;
      end
    end
    drop_err_d = drop_err_q | (push & full & ~pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cap_state_q <= CAP_IDLE;
      cmd_q       <= '0;
      op1_q       <= '0;
      ex_state_q  <= EX_IDLE;
      cnt_q       <= '0;
      cur_req_q   <= '0;
      rsp_q       <= '{resp: NONE, data: '0};
      drop_err_q  <= 1'b0;
    end else begin
      cap_state_q <= cap_state_d;
      cmd_q       <= cmd_d;
      op1_q       <= op1_d;
      ex_state_q  <= ex_state_d;
      cnt_q       <= cnt_d;
      cur_req_q   <= cur_req_d;
      rsp_q       <= rsp_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign out_resp = rsp_q.resp;
  assign out_data = rsp_q.data;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench: dut 0 (LATENCY=3, DEPTH=4) runs directed and random traffic, dut 1 (LATENCY=15, DEPTH=2) runs the overflow case.
// A reference model predicts each response, its arrival edge and any drops, and a negedge monitor checks each response against it.
module tb_calc_port_responder;

  logic        c_clk = 1'b0;
  logic        rst_n   [2];
  logic [3:0]  cmd_in  [2];
  logic [31:0] data_in [2];
  logic [1:0]  resp    [2];
  logic [31:0] odata   [2];
  logic        drop    [2];

  always #5 c_clk = ~c_clk;

  calc_port_responder #(.LATENCY(3), .DEPTH(4)) u_dut (
    .c_clk       (c_clk),
    .reset       (rst_n[0]),
    .req_cmd_in  (cmd_in[0]),
    .req_data_in (data_in[0]),
    .out_resp    (resp[0]),
    .out_data    (odata[0]),
    .drop_err    (drop[0])
  );

  calc_port_responder #(.LATENCY(15), .DEPTH(2)) u_ovf (
    .c_clk       (c_clk),
    .reset       (rst_n[1]),
    .req_cmd_in  (cmd_in[1]),
    .req_data_in (data_in[1]),
    .out_resp    (resp[1]),
    .out_data    (odata[1]),
    .drop_err    (drop[1])
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q    [2][$];
  int   acc_push [2][$];
  int   acc_pop  [2][$];
  int   last_load  [2];
  bit   drop_model [2];
  int   resp_count [2];
  int   accepted   [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  always @(posedge c_clk) cyc++;

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : 15;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Unsigned 32-bit calculator semantics, computed in wide arithmetic.
  task automatic ref_calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          output logic [1:0] r, output logic [31:0] y);
    logic [63:0] wide;
    r = 2'd3;
    y = '0;
    case (cmd)
      4'd1: begin
        wide = {32'd0, a} + {32'd0, b};
        if (wide > 64'h0000_0000_FFFF_FFFF) r = 2'd2;
        else begin r = 2'd1; y = wide[31:0]; end
      end
      4'd2: begin
        if (a < b) r = 2'd2;
        else begin r = 2'd1; y = a - b; end
      end
`ifdef CALC_SHIFT_EN
      4'd5: begin r = 2'd1; y = a << (b % 32); end
      4'd6: begin r = 2'd1; y = a >> (b % 32); end
`endif
      default: ;
    endcase
  endtask

  // Request entering the queue at edge p: decide whether it is dropped, and if not, when its result appears.
  task automatic model_req(input int d, input int p, input logic [3:0] cmd,
                           input logic [31:0] a, input logic [31:0] b);
    int   present = 0;
    bit   popping = 0;
    int   pop_e;
    exp_t e;
    for (int j = 0; j < acc_pop[d].size(); j++) begin
      if (acc_push[d][j] < p && acc_pop[d][j] >= p) begin
        present++;
        if (acc_pop[d][j] == p) popping = 1;
      end
    end
    if (present == depth_of(d) && !popping) begin
      drop_model[d] = 1'b1;
      return;
    end
    pop_e = (p + 1 > last_load[d]) ? p + 1 : last_load[d];
    last_load[d] = pop_e + lat_of(d);
    acc_push[d].push_back(p);
    acc_pop[d].push_back(pop_e);
    ref_calc(cmd, a, b, e.resp, e.data);
    e.due = last_load[d];
    exp_q[d].push_back(e);
    accepted[d]++;
  endtask

  task automatic model_reset(input int d);
    exp_q[d].delete();
    acc_push[d].delete();
    acc_pop[d].delete();
    last_load[d]  = 0;
    drop_model[d] = 1'b0;
  endtask

  // Called just after a posedge; returns just after the edge that pushes op2.
  task automatic issue(input int d, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] junk);
    int p;
    cmd_in[d]  = cmd;
    data_in[d] = a;
    @(posedge c_clk); #1;
    cmd_in[d]  = (cmd == 4'd0) ? 4'd0 : junk;
    data_in[d] = b;
    @(posedge c_clk); #1;
    p = cyc;
    cmd_in[d]  = 4'd0;
    data_in[d] = $urandom;
    if (cmd != 4'd0) model_req(d, p, cmd, a, b);
    check($sformatf("drop_err_d%0d", d), 64'(drop[d]), 64'(drop_model[d]));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 400) begin
      @(posedge c_clk); #1;
      n++;
    end
    check("drain_pending", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    repeat (3) @(posedge c_clk);
    #1;
  endtask

  always @(negedge c_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resp[d] != 2'd0) begin
        resp_count[d]++;
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp_d%0d: got resp %0d data 0x%0h at edge %0d, required no response",
                   d, resp[d], odata[d], cyc);
        end else begin
          mon_e = exp_q[d].pop_front();
          check($sformatf("resp_d%0d", d), 64'(resp[d]), 64'(mon_e.resp));
          check($sformatf("data_d%0d", d), 64'(odata[d]), 64'(mon_e.data));
          check($sformatf("edge_d%0d", d), 64'(cyc), 64'(mon_e.due));
        end
      end
    end
  end

  initial begin
    int          snap;
    logic [3:0]  c;
    logic [31:0] a, b;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cmd_in[d] = '0; data_in[d] = '0;
      resp_count[d] = 0; accepted[d] = 0;
      model_reset(d);
    end
    repeat (3) @(posedge c_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_resp_d%0d", d), 64'(resp[d]), 64'd0);
      check($sformatf("rst_data_d%0d", d), 64'(odata[d]), 64'd0);
      check($sformatf("rst_drop_d%0d", d), 64'(drop[d]), 64'd0);
      rst_n[d] = 1'b1;
    end

    // Directed cases; the first one measures the idle latency of k+5.
    issue(0, 4'd1, 32'h64, 32'h27, 4'd0);
    drain();
    snap = resp_count[0];
    issue(0, 4'd0, 32'h64, 32'h27, 4'd0);
    repeat (20) @(posedge c_clk);
    #1;
    check("nop_no_resp", 64'(resp_count[0] - snap), 64'd0);
    issue(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 4'd0);
    issue(0, 4'd2, 32'h22, 32'h23, 4'd0);
    issue(0, 4'd5, 32'h3, 32'h22, 4'd0);
    issue(0, 4'd6, 32'hC, 32'h2, 4'd0);
    issue(0, 4'hF, 32'h1234, 32'h5678, 4'd0);
    drain();
    snap = resp_count[0];
    issue(0, 4'd1, 32'd10, 32'd20, 4'hA);
    drain();
    check("operand_cycle_one_resp", 64'(resp_count[0] - snap), 64'd1);

    // Random traffic with random gaps; back-to-back bursts can fill the queue.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: c = 4'd0;
        1, 2: c = 4'd1;
        3: c = 4'd2;
        4: c = 4'd5;
        5: c = 4'd6;
        default: c = 4'($urandom_range(1, 15));
      endcase
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(0, c, a, b, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge c_clk);
      #1;
    end
    drain();

    // Overflow: six back-to-back adds into DEPTH=2, LATENCY=15.
    for (int i = 0; i < 6; i++) issue(1, 4'd1, $urandom >> 1, $urandom >> 1, 4'd0);
    check("ovf_drop_err", 64'(drop[1]), 64'd1);
    drain();
    check("ovf_resp_count", 64'(resp_count[1]), 64'(accepted[1]));

    // Reset pulse two cycles after a command, which must not be answered.
    snap = resp_count[0];
    cmd_in[0] = 4'd1; data_in[0] = 32'h7;
    @(posedge c_clk); #1;
    cmd_in[0] = 4'd0; data_in[0] = 32'h8;
    @(posedge c_clk); #1;
    @(posedge c_clk); #1;
    rst_n[0] = 1'b0;
    model_reset(0);
    @(posedge c_clk); #1;
    check("rst_mid_resp", 64'(resp[0]), 64'd0);
    check("rst_mid_data", 64'(odata[0]), 64'd0);
    check("rst_mid_drop", 64'(drop[0]), 64'd0);
    rst_n[0] = 1'b1;
    repeat (20) @(posedge c_clk);
    #1;
    check("rst_no_resp", 64'(resp_count[0] - snap), 64'd0);
    issue(0, 4'd1, 32'h5, 32'h1, 4'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
# calc_port_responder

Single-channel responder for the calculator request protocol. It accepts a command with operand 1, captures operand 2 on the following cycle, queues the request, executes it after a fixed latency, and drives a one-cycle response/data pair. Four instances form the response side of a 4-port calculator, one per `reqN`/`outN` channel.

## Interface
- `LATENCY`, default 3: execution cycles per request. Legal range 1..15.
- `DEPTH`, default 4: request queue entries. Must be a power of 2 and at least 2.

Ports:
- `c_clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_cmd_in`  in  4  command; nonzero starts a request.
- `req_data_in`  in  32  operand 1 in the command cycle, operand 2 in the next cycle.
- `out_resp`  out  2  0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- `out_data`  out  32  result; valid only when `out_resp`==1, otherwise 0.
- `drop_err`  out  1  sticky; a completed request was lost because the queue was full.

## Operation
- Capture FSM, states CAP_IDLE and CAP_OP2.
  - In CAP_IDLE, nonzero `req_cmd_in` at edge k latches cmd and op1, then moves to CAP_OP2.
  - In CAP_OP2, edge k+1 latches op2, pushes {cmd, op1, op2} to the queue and returns to CAP_IDLE.
  - `req_cmd_in` during the operand cycle is ignored and never starts a request.
  - cmd 0 is a no-op: it never produces a response.
- Queue: DEPTH-entry FIFO.
  - Push when full with no pop on the same edge: the request is discarded and `drop_err` is set.
  - Push and pop on the same edge when full: both happen and nothing is dropped.
- Execute FSM, states EX_IDLE and EX_BUSY.
  - In EX_IDLE with the queue non-empty: pop, load counter = LATENCY-1, go to EX_BUSY.
  - In EX_BUSY with counter != 0: decrement.
  - In EX_BUSY with counter == 0: register the result onto the outputs. If the queue is non-empty, pop the next entry and reload the counter (stay in EX_BUSY); otherwise go to EX_IDLE.
- Arithmetic (all unsigned, 32-bit):
  - cmd 1, add: compute a 33-bit sum. Carry out gives resp 2 and data 0; otherwise resp 1 and data sum[31:0].
  - cmd 2, subtract: op1 < op2 gives resp 2 and data 0; otherwise resp 1 and data op1-op2.
  - cmd 5: shift left, data op1 << op2[4:0], resp 1. op2[31:5] is ignored.
  - cmd 6: shift right (logical), data op1 >> op2[4:0], resp 1. op2[31:5] is ignored.
  - Any other nonzero cmd: resp 3, data 0.
- Output pulse: `out_resp` and `out_data` hold for exactly one cycle and return to 0 on the next edge unless a new result loads on that edge.

## Timing
- Reset values: `out_resp`=0, `out_data`=0, `drop_err`=0; FSMs in CAP_IDLE/EX_IDLE; queue empty; counter 0.
- Reset asserted mid-operation: all in-flight and queued requests are discarded with no response. After release, the first command is accepted on the first edge.
- Latency from an idle block:
  - Command at edge k, op2 at edge k+1, pop at edge k+2, outputs load at edge k+2+LATENCY.
  - With LATENCY=3, the response is visible in the cycle following edge k+5.
- Back-to-back commands are accepted every 2 cycles. Sustained results come out every LATENCY cycles.
- When LATENCY>2, the queue absorbs the difference in rates and fills under sustained traffic.
- Responses always come out in request order.

## Configuration
- `CALC_SHIFT_EN` defined: cmds 5 and 6 execute as shifts.
- `CALC_SHIFT_EN` undefined: the shifters are not built, and cmds 5 and 6 return resp 3 with data 0. Timing and latency are unchanged.

## Structure
- Package `calc_pkg`:
  - `cmd_e` enum: NOP=0, ADD=1, SUB=2, SHL=5, SHR=6.
  - `resp_e` enum: NONE=0, OK=1, OVF=2, INVALID=3.
  - `calc_req_t` struct: {cmd, op1, op2}.
  - `CALC_DATA_W`=32.
- Sub-module `calc_req_fifo`: parameterized by DEPTH, with push/pop/full/empty and pointers one bit wider than the index. The capture and execute FSMs stay in the top level.

## Test plan
- Add, cmd 1, op1 0x64, op2 0x27, LATENCY=3: resp 1 with data 0x8B, one cycle long, in the cycle after edge k+5. cmd 0 with the same data: no response for 20 cycles.
- Add overflow, cmd 1, 0xFFFFFFFF + 0x1: resp 2, data 0. Subtract underflow, cmd 2, 0x22 − 0x23: resp 2, data 0.
- Shifts, cmd 5 with 0x3 and op2 0x22: data 0xC (only op2[4:0]=2 is used). cmd 6 with 0xC and 0x2: data 0x3. Without `CALC_SHIFT_EN`, both return resp 3.
- Invalid cmd 0xF: resp 3, data 0. A nonzero cmd driven during an operand cycle: exactly one response.
- DEPTH=2, LATENCY=15, six commands back-to-back: `drop_err` rises once the queue overflows, and the responses that do appear match the accepted requests in order.
- Reset pulse two cycles after a command: no response afterwards, all outputs 0, and a following add 0x5 + 0x1 returns 0x6.
